// File: rtl/inv_chk_pkg.sv
// Shared types, default constants and the Galois LFSR step for the inverter co-sim checker.
// lfsr_next works on up to 32-bit registers; callers zero-extend and truncate.
package inv_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_LFSR_W = 16;
  localparam logic [31:0] DEF_TAPS   = 32'h0000_B400;
  localparam logic [31:0] DEF_SEED   = 32'h0000_ACE1;
  localparam int unsigned DEF_CNT_W  = 16;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/inv_sync2.sv
// Two-flop synchroniser for the asynchronous inverter output, built from library flop cells.
module inv_sync2 (
  input  logic CLK,
  input  logic RESET_B,
  input  logic dut_i,
  output logic dut_sync
);

  logic meta;

  sg13g2_dfrbpq_1 u_ff0 (.CLK(CLK), .RESET_B(RESET_B), .D(dut_i), .Q(meta));
  sg13g2_dfrbpq_1 u_ff1 (.CLK(CLK), .RESET_B(RESET_B), .D(meta),  .Q(dut_sync));

endmodule

// File: rtl/sg13g2_dfrbpq_1.sv
// Behavioural stand-in for the IHP sg13g2_dfrbpq_1 cell: rising-edge D flop, async active-low reset.
module sg13g2_dfrbpq_1 (
  input  logic CLK,
  input  logic RESET_B,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) Q <= 1'b0;
    else          Q <= D;
  end

endmodule

// File: rtl/inv_cosim_checker.sv
// Stimulus/response checker for the co-simulated inverter: LFSR stimulus, synchronised sampling, counting.
// Optional first_err_idx output enabled by defining INV_CHK_FIRST_ERR_EN.
//
//  state | meaning
//  IDLE  | no run since reset; waiting for start
//  RUN   | emitting one LFSR vector per cycle
//  DRAIN | stimulus held; waiting for in-flight vectors to be compared
//  DONE  | run complete, counts valid; start begins a new run
module inv_cosim_checker
  import inv_chk_pkg::*;
#(
  parameter int unsigned       LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEF_SEED),
  parameter int unsigned       LAT    = 2,
  parameter int unsigned       CNT_W  = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             start,
  input  logic [CNT_W-1:0] n_vectors,
  output logic             stim_o,
  input  logic             dut_i,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef INV_CHK_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] first_err_idx
`endif
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  remaining;
  logic              stim_vld;
  logic [LAT-1:0]    vld_pipe, exp_pipe, vld_body;
  logic              dut_sync, accept, tail_vld, mismatch;

  inv_sync2 u_sync (
    .CLK      (CLK),
    .RESET_B  (RESET_B),
    .dut_i    (dut_i),
    .dut_sync (dut_sync)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign tail_vld = vld_pipe[LAT-1];
  assign mismatch = tail_vld && (dut_sync != ~exp_pipe[LAT-1]);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // The tail entry is consumed on the same edge that DRAIN exits, so only the body must be empty.
  always_comb begin
    vld_body          = vld_pipe;
    vld_body[LAT-1]   = 1'b0;
    state_nxt         = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = (n_vectors == '0) ? DRAIN : RUN;
      RUN:        if (remaining == CNT_W'(1)) state_nxt = DRAIN;
      DRAIN:      if (!stim_vld && (vld_body == '0)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // stim_vld/stim_o form stage zero; the pipeline adds LAT stages to match the synchroniser.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      remaining <= '0;
      stim_o    <= 1'b0;
      stim_vld  <= 1'b0;
      vld_pipe  <= '0;
      exp_pipe  <= '0;
    end else begin
      state       <= state_nxt;
      stim_vld    <= (state == RUN);
      vld_pipe[0] <= stim_vld;
      exp_pipe[0] <= stim_o;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
      end
      if (accept) begin
        remaining <= n_vectors;
        lfsr      <= SEED_EFF;
      end else if (state == RUN) begin
        stim_o    <= lfsr[0];
        lfsr      <= LFSR_W'(lfsr_next(32'(lfsr), 32'(TAPS)));
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      vec_cnt <= '0;
      err_cnt <= '0;
    end else if (tail_vld) begin
      vec_cnt <= vec_cnt + CNT_W'(1);
      if (mismatch && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifdef INV_CHK_FIRST_ERR_EN
  logic err_seen;

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      first_err_idx <= '0;
      err_seen      <= 1'b0;
    end else if (accept) begin
      first_err_idx <= CNT_MAX;
      err_seen      <= 1'b0;
    end else if (mismatch && !err_seen) begin
      first_err_idx <= vec_cnt;
      err_seen      <= 1'b1;
    end
  end
`endif

endmodule
